// File: rtl/aes_rng_pkg.sv
// Shared types and xoshiro128++ helpers for the masked-AES PRNG.
// The bench model calls the same functions.
package aes_rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WARMUP    = 2'd1,
    ST_RUN       = 2'd2,
    ST_NEED_SEED = 2'd3
  } prng_state_e;

  localparam logic [31:0] PRNG_ZERO_SEED_FIX = 32'h9E3779B9;

  // Field order matches the seed bus: seed[31:0] lands in s0.
  typedef struct packed {
    logic [31:0] s3;
    logic [31:0] s2;
    logic [31:0] s1;
    logic [31:0] s0;
  } xo_state_t;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned sh);
    return (x << sh) | (x >> (32 - sh));
  endfunction

  // The all-zero state is a fixed point of the step, so it is replaced.
  function automatic xo_state_t xoshiro_seed(input logic [127:0] seed);
    xo_state_t s;
    s = seed;
    if (seed == '0) s.s0 = PRNG_ZERO_SEED_FIX;
    return s;
  endfunction

  function automatic xo_state_t xoshiro_step(input xo_state_t s);
    xo_state_t n;
    logic [31:0] t;
    n = s;
    t = s.s1 << 9;
    n.s2 = n.s2 ^ n.s0;
    n.s3 = n.s3 ^ n.s1;
    n.s1 = n.s1 ^ n.s2;
    n.s0 = n.s0 ^ n.s3;
    n.s2 = n.s2 ^ t;
    n.s3 = rotl32(n.s3, 11);
    return n;
  endfunction

  function automatic logic [31:0] xoshiro_out(input xo_state_t s);
    logic [31:0] sum;
    sum = s.s0 + s.s3;
    return rotl32(sum, 7) + s.s0;
  endfunction

endpackage

// File: rtl/aes_prng_core.sv
// 128-bit xoshiro128++ state register with load/step controls.
// The output word depends only on the registered state.
module aes_prng_core
  import aes_rng_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [127:0] seed_i,
  input  logic         step_i,
  output logic [31:0]  data_o
);

  xo_state_t st_q, st_d;

  always_comb begin
    st_d = st_q;
    if (load_i)      st_d = xoshiro_seed(seed_i);
    else if (step_i) st_d = xoshiro_step(st_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= '0;
    else        st_q <= st_d;
  end

  assign data_o = xoshiro_out(st_q);

endmodule

// File: rtl/aes_prng.sv
// Seeded xoshiro128++ word source with warm-up and reseed limit.
// FSM and counters live here; the state register is in aes_prng_core.
module aes_prng
  import aes_rng_pkg::*;
#(
  parameter int WARMUP_ROUNDS   = 16,
  parameter int RESEED_INTERVAL = 65536,
  parameter int CNT_W           = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [127:0] seed_i,
  input  logic         seed_valid_i,
  output logic         seed_ready_o,
  output logic [31:0]  out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         reseed_req_o,
  output logic         busy_o
);

  localparam int WU_W = (WARMUP_ROUNDS > 0) ? $clog2(WARMUP_ROUNDS + 1) : 1;
  localparam logic [WU_W-1:0]  WU_LAST = WU_W'(WARMUP_ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESEED_INTERVAL);

  prng_state_e      state_q, state_d;
  logic [WU_W-1:0]  wu_q, wu_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             accept, hs, load, step;

  assign seed_ready_o = (state_q != ST_WARMUP);
  assign out_valid_o  = (state_q == ST_RUN);
  assign busy_o       = (state_q == ST_WARMUP);
  assign reseed_req_o = (state_q == ST_IDLE) || (state_q == ST_NEED_SEED);

  assign accept  = seed_valid_i && seed_ready_o;
  assign hs      = out_valid_o && out_ready_i;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    wu_d    = wu_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    // A seed wins over a same-cycle output handshake: the state is reloaded.
    if (accept) begin
      load    = 1'b1;
      cnt_d   = '0;
      wu_d    = '0;
      state_d = (WARMUP_ROUNDS > 0) ? ST_WARMUP : ST_RUN;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          step = 1'b1;
          if (wu_q == WU_LAST) begin
            wu_d    = '0;
            state_d = ST_RUN;
          end else begin
            wu_d = wu_q + WU_W'(1);
          end
        end
        ST_RUN: begin
          if (hs) begin
            step  = 1'b1;
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) state_d = ST_NEED_SEED;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      wu_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wu_q    <= wu_d;
      cnt_q   <= cnt_d;
    end
  end

  aes_prng_core u_core (
    .clk    (clk),
    .rst_n  (resetn),
    .load_i (load),
    .seed_i (seed_i),
    .step_i (step),
    .data_o (out_data_o)
  );

endmodule

// File: tb/tb_aes_prng.sv
// Scoreboard bench: dut_a has no warm-up and a large reseed limit,
// dut_b has 16 warm-up rounds and a reseed limit of 4.
module tb_aes_prng;
  import aes_rng_pkg::*;

  localparam logic [127:0] SEED1 = {32'd4, 32'd3, 32'd2, 32'd1};

  logic         clk = 1'b0, resetn = 1'b0;
  logic [127:0] a_seed = '0, b_seed = '0;
  logic         a_sv = 1'b0, b_sv = 1'b0, a_rdy = 1'b0, b_rdy = 1'b0;
  logic         a_srdy, a_vld, a_req, a_busy, b_srdy, b_vld, b_req, b_busy;
  logic [31:0]  a_data, b_data;

  int          errors = 0, checks = 0, a_zero = 0;
  logic [31:0] qa[$], qb[$];
  bit          mon_en = 1'b0;
  logic        a_pv = 0, a_pr = 0, a_pacc = 0, b_pv = 0, b_pr = 0, b_pacc = 0;
  logic [31:0] a_pd = '0, b_pd = '0;

  aes_prng #(.WARMUP_ROUNDS(0), .RESEED_INTERVAL(65536), .CNT_W(32)) dut_a (
    .clk(clk), .resetn(resetn), .seed_i(a_seed), .seed_valid_i(a_sv),
    .seed_ready_o(a_srdy), .out_data_o(a_data), .out_valid_o(a_vld),
    .out_ready_i(a_rdy), .reseed_req_o(a_req), .busy_o(a_busy));

  aes_prng #(.WARMUP_ROUNDS(16), .RESEED_INTERVAL(4), .CNT_W(8)) dut_b (
    .clk(clk), .resetn(resetn), .seed_i(b_seed), .seed_valid_i(b_sv),
    .seed_ready_o(b_srdy), .out_data_o(b_data), .out_valid_o(b_vld),
    .out_ready_i(b_rdy), .reseed_req_o(b_req), .busy_o(b_busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_push(input bit to_b, input logic [127:0] seed, input int wr,
                            input int skip, input int n);
    xo_state_t st;
    st = xoshiro_seed(seed);
    repeat (wr) st = xoshiro_step(st);
    for (int i = 0; i < skip + n; i++) begin
      if (i >= skip) begin
        if (to_b) qb.push_back(xoshiro_out(st));
        else      qa.push_back(xoshiro_out(st));
      end
      st = xoshiro_step(st);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain_a(input string tag, input int budget);
    int n = 0;
    while (qa.size() != 0 && n < budget) begin @(posedge clk); n++; end
    #1;
    chk(tag, 64'(qa.size()), 0);
  endtask

  task automatic chk_rst(input string p, input logic vld, input logic [31:0] d,
                         input logic req, input logic busy, input logic srdy);
    chk({p, "_vld"}, 64'(vld), 0);
    chk({p, "_data"}, 64'(d), 0);
    chk({p, "_req"}, 64'(req), 1);
    chk({p, "_busy"}, 64'(busy), 0);
    chk({p, "_srdy"}, 64'(srdy), 1);
  endtask

  // Monitors: pop on every handshake, and a word must hold while stalled.
  always @(negedge clk) begin
    logic [31:0] w;
    if (mon_en && resetn) begin
      if (a_pv && !a_pr && !a_pacc && a_vld) chk("a_hold", 64'(a_data), 64'(a_pd));
      if (a_vld && a_rdy) begin
        if (qa.size() == 0) chk("a_extra_word", 64'(qa.size()), 1);
        else begin
          w = qa.pop_front();
          chk("a_word", 64'(a_data), 64'(w));
          if (a_data == 32'd0) a_zero++;
        end
      end
      if (b_pv && !b_pr && !b_pacc && b_vld) chk("b_hold", 64'(b_data), 64'(b_pd));
      if (b_vld && b_rdy) begin
        if (qb.size() == 0) chk("b_extra_word", 64'(qb.size()), 1);
        else begin
          w = qb.pop_front();
          chk("b_word", 64'(b_data), 64'(w));
        end
      end
    end
    a_pv = a_vld; a_pr = a_rdy; a_pacc = a_sv && a_srdy; a_pd = a_data;
    b_pv = b_vld; b_pr = b_rdy; b_pacc = b_sv && b_srdy; b_pd = b_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s;
    logic [31:0]  c;
    int nb, nbad, n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("rst_a", a_vld, a_data, a_req, a_busy, a_srdy);
    chk_rst("rst_b", b_vld, b_data, b_req, b_busy, b_srdy);
    tick();
    resetn = 1'b1;
    mon_en = 1'b1;
    tick();

    // Known first words, then 998 model words.
    qa.push_back(32'd641);
    qa.push_back(32'd1573767);
    model_push(0, SEED1, 0, 2, 998);
    a_seed = SEED1; a_sv = 1'b1; a_rdy = 1'b1;
    @(negedge clk);
    chk("t1_srdy_acc", 64'(a_srdy), 1);
    chk("t1_vld_pre", 64'(a_vld), 0);
    @(posedge clk); #1 a_sv = 1'b0;
    @(negedge clk);
    chk("t1_vld_rise", 64'(a_vld), 1);
    drain_a("t1_drain", 2000);
    a_rdy = 1'b0;

    // Random back-pressure.
    s = {$urandom, $urandom, $urandom, $urandom};
    model_push(0, s, 0, 0, 300);
    a_seed = s; a_sv = 1'b1; tick(); a_sv = 1'b0;
    n = 0;
    while (qa.size() != 0 && n < 3000) begin
      a_rdy = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    a_rdy = 1'b0;
    chk("t3_drain", 64'(qa.size()), 0);

    // All-zero seed.
    model_push(0, '0, 0, 0, 1000);
    a_zero = 0;
    a_seed = '0; a_sv = 1'b1; tick(); a_sv = 1'b0;
    @(negedge clk);
    c = 32'h9E3779B9;
    chk("t5_first", 64'(a_data), 64'({c[24:0], c[31:25]} + c));
    tick();
    a_rdy = 1'b1;
    drain_a("t5_drain", 2000);
    a_rdy = 1'b0;
    chk("t5_zero_words", 64'(a_zero), 0);

    // Warm-up and reseed limit on dut_b.
    for (int r = 0; r < 2; r++) begin
      s = (r == 0) ? SEED1 : {$urandom, $urandom, $urandom, $urandom};
      model_push(1, s, 16, 0, 4);
      b_rdy = 1'b1;
      b_seed = s; b_sv = 1'b1; tick(); b_sv = 1'b0;
      nb = 0; nbad = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (b_busy) begin
          nb++;
          if (b_srdy || b_vld) nbad++;
        end
      end
      chk($sformatf("t2_busy_cycles_%0d", r), 64'(nb), 16);
      chk($sformatf("t2_busy_srdy_%0d", r), 64'(nbad), 0);
      chk($sformatf("t4_drain_%0d", r), 64'(qb.size()), 0);
      chk($sformatf("t4_vld_%0d", r), 64'(b_vld), 0);
      chk($sformatf("t4_req_%0d", r), 64'(b_req), 1);
      chk($sformatf("t4_srdy_%0d", r), 64'(b_srdy), 1);
      tick();
    end
    b_rdy = 1'b0;

    // Reset with dut_a streaming and dut_b in warm-up.
    s = {$urandom, $urandom, $urandom, $urandom};
    model_push(0, s, 0, 0, 200);
    a_seed = s; b_seed = s; a_sv = 1'b1; b_sv = 1'b1; tick();
    a_sv = 1'b0; b_sv = 1'b0; a_rdy = 1'b1;
    repeat (5) tick();
    chk("t6_pre_a_vld", 64'(a_vld), 1);
    chk("t6_pre_b_busy", 64'(b_busy), 1);
    mon_en = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk_rst("t6_async_a", a_vld, a_data, a_req, a_busy, a_srdy);
    chk_rst("t6_async_b", b_vld, b_data, b_req, b_busy, b_srdy);
    qa.delete();
    qb.delete();
    repeat (2) tick();
    resetn = 1'b1;
    repeat (4) tick();
    chk_rst("t6_after_a", a_vld, a_data, a_req, a_busy, a_srdy);
    chk_rst("t6_after_b", b_vld, b_data, b_req, b_busy, b_srdy);
    a_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_prng.md
Name: aes_prng

Overview:
Upstream entropy source for the masked-AES randomness generator. Expands a 128-bit seed with xoshiro128++ into a stream of 32-bit words on a valid/ready interface. The randomness generator packs these words into its mask and refresh outputs in the synthesis (non-SIM) build. Enforces a warm-up period after each seed and a reseed limit.

Parameters:
WARMUP_ROUNDS, 16, number of discarded state steps after each seed load (0 allowed)
RESEED_INTERVAL, 65536, words delivered before output stalls and a new seed is required (>=1)
CNT_W, 32, width of the delivered-word counter; must hold RESEED_INTERVAL

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
seed_i  in  128  seed; s0=seed_i[31:0] … s3=seed_i[127:96]
seed_valid_i  in  1  seed offered
seed_ready_o  out  1  seed accepted when valid&ready
out_data_o  out  32  random word
out_valid_o  out  1  out_data_o valid
out_ready_i  in  1  consumer takes word
reseed_req_o  out  1  a new seed is required
busy_o  out  1  high in WARMUP

Behaviour:
- Interface decision: one clock `clk`; reset `resetn` is asynchronous and active-low.
- Reset: FSM=IDLE, s0..s3=0, warm-up counter=0, word counter=0. Outputs: out_valid_o=0, out_data_o=f(0)=0, reseed_req_o=1, busy_o=0, seed_ready_o=1.
- States: IDLE, WARMUP, RUN, NEED_SEED (2-bit encoding).
- seed_ready_o = (state != WARMUP), combinational from the state register only.
- Seed accept (valid&ready), from IDLE, RUN or NEED_SEED:
  - Load s0..s3 from seed_i. An all-zero seed instead loads s0=32'h9E3779B9, s1=s2=s3=0.
  - Clear the word counter.
  - Go to WARMUP if WARMUP_ROUNDS>0, else go to RUN.
  - In RUN, an accept has priority over a simultaneous output handshake. The word on that cycle counts as consumed, but the state is not stepped; it is overwritten by the seed.
- WARMUP:
  - Step the state once per cycle for exactly WARMUP_ROUNDS cycles, then go to RUN.
  - out_valid_o=0, busy_o=1. seed_valid_i is ignored.
- Step function (one cycle):
  - t = s1<<9
  - s2 ^= s0; s3 ^= s1; s1 ^= s2; s0 ^= s3; s2 ^= t; s3 = rotl(s3,11)
  - All sequential, mod 2^32.
- Output function: out_data_o = rotl(s0+s3, 7) + s0, mod 2^32. It is computed combinationally from the state registers only; there is no input-to-output combinational path.
- RUN: out_valid_o=1. Word held stable until out_ready_i. On a handshake:
  - Step the state and increment the word counter.
  - If the counter reaches RESEED_INTERVAL, go to NEED_SEED.
- Latency: seed accepted at cycle T → first word valid at T+1+WARMUP_ROUNDS. Sustained throughput is one word per cycle under continuous ready.
- NEED_SEED: out_valid_o=0; hold the state; wait for a seed.
- reseed_req_o = 1 in IDLE and NEED_SEED, 0 otherwise (registered state decode).
- Reset mid-operation: immediately returns to the reset values above. No partial word is delivered afterwards.
- Counter never wraps: the transition to NEED_SEED happens exactly at RESEED_INTERVAL.

Decomposition:
- Shared package aes_rng_pkg:
  - prng_state_e enum
  - PRNG_ZERO_SEED_FIX constant (32'h9E3779B9)
  - xoshiro_step and xoshiro_out functions, so the TB model reuses them
- One natural sub-module, aes_prng_core: the 128-bit state register with load/step controls and the output function. The FSM and counters stay in the top.

Test Plan:
1. WARMUP_ROUNDS=0, seed {s3..s0}={4,3,2,1}, out_ready_i=1:
   - seed_ready_o=1 at accept
   - out_valid_o rises next cycle
   - words 32'd641, then 32'd1573767
   - then a match against the package model for 1000 words
2. WARMUP_ROUNDS=16, same seed:
   - busy_o=1 for exactly 16 cycles and seed_ready_o=0 during them
   - first word equals model word #17 from the unwarmed seed
3. out_ready_i toggled randomly:
   - out_data_o stable while valid&!ready
   - no word dropped or duplicated against the model
4. RESEED_INTERVAL=4:
   - after the 4th handshake, out_valid_o=0 and reseed_req_o=1
   - a new seed restarts the stream; counter restarts at 0
5. All-zero seed:
   - state loads 9E3779B9/0/0/0
   - first word = rotl(32'h9E3779B9,7)+32'h9E3779B9
   - output never stuck at 0 over 1000 words
6. Reset during WARMUP and during RUN with ready=1:
   - all outputs return to reset values asynchronously
   - seed_ready_o=1 afterwards
